// File: rtl/mem_io_responder.sv
// Byte-wide CPU memory responder: RAM, unmapped hole and an I/O page holding TX/RX byte
// FIFOs, a free-running cycle counter with snapshot latch and a sticky halt flag.
module mem_io_responder #(
   parameter int unsigned RAM_AW   = 17,
   parameter int unsigned TX_DEPTH = 8,
   parameter int unsigned RX_DEPTH = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        halt,
   output logic        tx_overflow
);

   localparam int unsigned TxPw = $clog2(TX_DEPTH);
   localparam int unsigned RxPw = $clog2(RX_DEPTH);
   localparam logic [TxPw:0] TxFull = (TxPw + 1)'(TX_DEPTH);
   localparam logic [RxPw:0] RxFull = (RxPw + 1)'(RX_DEPTH);

   logic [7:0]        ram_q    [2**RAM_AW];
   logic [7:0]        tx_mem_q [TX_DEPTH];
   logic [7:0]        rx_mem_q [RX_DEPTH];
   logic [TxPw-1:0]   tx_rptr_q, tx_wptr_q;
   logic [TxPw:0]     tx_cnt_q;
   logic [RxPw-1:0]   rx_rptr_q, rx_wptr_q;
   logic [RxPw:0]     rx_cnt_q;
   logic [7:0]        mem_din_q;
   logic [31:0]       cnt_q, snap_q;
   logic              halt_q, tx_ovf_q;

   logic [RAM_AW-1:0] ram_addr;
   logic [2:0]        io_off;
   logic              is_ram, is_io, cpu_rd, cpu_wr, io_wr4;
   logic              tx_req, tx_push, tx_pop, tx_full;
   logic              rx_push, rx_pop, rx_empty;
   logic [7:0]        tx_wdata, rd_data;
   logic              unused_a;

   assign unused_a = ^mem_a[31:18];
   assign ram_addr = mem_a[RAM_AW-1:0];
   assign io_off   = mem_a[2:0];
   assign is_ram   = ~mem_a[17];
   assign is_io    = mem_a[17] & mem_a[16];
   assign cpu_rd   = rdy_in & ~mem_wr;
   assign cpu_wr   = rdy_in & mem_wr;

   // Halt write also emits a 0x00 terminator byte into the TX stream.
   assign io_wr4   = cpu_wr & is_io & (io_off == 3'd4);
   assign tx_req   = io_wr4 | (cpu_wr & is_io & (io_off == 3'd0) & (mem_dout != 8'h00));
   assign tx_wdata = io_wr4 ? 8'h00 : mem_dout;
   assign tx_full  = (tx_cnt_q == TxFull);
   assign tx_pop   = tx_valid & tx_ready;
   assign tx_push  = tx_req & (~tx_full | tx_pop);

   assign rx_empty = (rx_cnt_q == '0);
   assign rx_push  = rx_valid & rx_ready;
   assign rx_pop   = cpu_rd & is_io & (io_off == 3'd0) & ~rx_empty;

   always_comb begin
      rd_data = 8'h00;
      if (is_ram) begin
         rd_data = ram_q[ram_addr];
      end else if (is_io) begin
         case (io_off)
            3'd0:    rd_data = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
            3'd4:    rd_data = cnt_q[7:0];
            3'd5:    rd_data = snap_q[15:8];
            3'd6:    rd_data = snap_q[23:16];
            3'd7:    rd_data = snap_q[31:24];
            default: rd_data = 8'h00;
         endcase
      end
   end

   // RAM survives reset.
   always_ff @(posedge clk_in) begin
      if (cpu_wr & is_ram) ram_q[ram_addr] <= mem_dout;
   end

   always_ff @(posedge clk_in) begin
      if (tx_push) tx_mem_q[tx_wptr_q] <= tx_wdata;
      if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mem_din_q <= 8'h00;
         cnt_q     <= 32'd0;
         snap_q    <= 32'd0;
         halt_q    <= 1'b0;
         tx_ovf_q  <= 1'b0;
         tx_rptr_q <= '0;
         tx_wptr_q <= '0;
         tx_cnt_q  <= '0;
         rx_rptr_q <= '0;
         rx_wptr_q <= '0;
         rx_cnt_q  <= '0;
      end else begin
         if (cpu_rd) mem_din_q <= rd_data;
         if (cpu_rd & is_io & (io_off == 3'd4)) snap_q <= cnt_q;
         if (rdy_in) cnt_q <= cnt_q + 32'd1;
         if (io_wr4) halt_q <= 1'b1;
         if (tx_req & ~tx_push) tx_ovf_q <= 1'b1;
         if (tx_push) tx_wptr_q <= tx_wptr_q + TxPw'(1);
         if (tx_pop) tx_rptr_q <= tx_rptr_q + TxPw'(1);
         tx_cnt_q <= tx_cnt_q + {{TxPw{1'b0}}, tx_push} - {{TxPw{1'b0}}, tx_pop};
         if (rx_push) rx_wptr_q <= rx_wptr_q + RxPw'(1);
         if (rx_pop) rx_rptr_q <= rx_rptr_q + RxPw'(1);
         rx_cnt_q <= rx_cnt_q + {{RxPw{1'b0}}, rx_push} - {{RxPw{1'b0}}, rx_pop};
      end
   end

   assign mem_din     = mem_din_q;
   assign halt        = halt_q;
   assign tx_overflow = tx_ovf_q;
   assign tx_valid    = (tx_cnt_q != '0);
   assign tx_data     = tx_mem_q[tx_rptr_q];
   assign rx_ready    = (rx_cnt_q != RxFull);

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus a randomized run checked against a
// queue-based transaction model of the memory map.
module tb_mem_io_responder;

   localparam int TxDepth = 8;
   localparam int RxDepth = 4;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic [31:0] mem_a = 32'h0002_0000;
   logic [7:0]  mem_dout = 8'h00;
   logic        mem_wr = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_ready = 1'b0;
   logic [7:0]  mem_din, tx_data;
   logic        rx_ready, tx_valid, halt, tx_overflow;

   int errors = 0;
   int checks = 0;

   mem_io_responder #(.RAM_AW(17), .TX_DEPTH(TxDepth), .RX_DEPTH(RxDepth)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
      .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din), .rx_valid(rx_valid),
      .rx_data(rx_data), .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .halt(halt), .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   // Transaction model: byte map, FIFOs as queues, counter as edges seen with rdy_in high.
   logic [7:0]  m_ram [int];
   logic [7:0]  m_tx [$];
   logic [7:0]  m_rx [$];
   logic [31:0] m_cnt, m_snap;
   logic [7:0]  m_din;
   logic        m_halt, m_ovf;
   bit          m_rx_push;
   int          m_key;

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         m_tx.delete();
         m_rx.delete();
         m_cnt = 0; m_snap = 0; m_din = 8'h00; m_halt = 1'b0; m_ovf = 1'b0;
      end else begin
         m_rx_push = rx_valid && (m_rx.size() < RxDepth);
         if (m_tx.size() != 0 && tx_ready) void'(m_tx.pop_front());
         if (rdy_in) begin
            m_key = int'(mem_a[16:0]);
            if (!mem_a[17]) begin
               if (mem_wr) m_ram[m_key] = mem_dout;
               else m_din = m_ram[m_key];
            end else if (!mem_a[16]) begin
               if (!mem_wr) m_din = 8'h00;
            end else if (mem_wr) begin
               if (mem_a[2:0] == 3'd4 || (mem_a[2:0] == 3'd0 && mem_dout != 8'h00)) begin
                  if (mem_a[2:0] == 3'd4) m_halt = 1'b1;
                  if (m_tx.size() < TxDepth) m_tx.push_back(mem_a[2:0] == 3'd4 ? 8'h00 : mem_dout);
                  else m_ovf = 1'b1;
               end
            end else begin
               case (mem_a[2:0])
                  3'd0: begin
                     if (m_rx.size() != 0) m_din = m_rx.pop_front();
                     else m_din = 8'h00;
                  end
                  3'd4: begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
                  3'd5: m_din = m_snap[15:8];
                  3'd6: m_din = m_snap[23:16];
                  3'd7: m_din = m_snap[31:24];
                  default: m_din = 8'h00;
               endcase
            end
            m_cnt = m_cnt + 32'd1;
         end
         if (m_rx_push) m_rx.push_back(rx_data);
      end
   end

   task automatic step();
      @(posedge clk_in); #1;
   endtask

   // Present one request for one edge, then park on an ignored unmapped write.
   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a = a; mem_wr = wr; mem_dout = d;
      step();
      mem_a = 32'h0002_0000; mem_wr = 1'b1; mem_dout = 8'h00;
   endtask

   task automatic test_reset();
      #1 rst_in = 1'b0;
      #1;
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din: got %h want 00", mem_din); end
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", halt); end
      checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", tx_overflow); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
      step(); step();
      rst_in = 1'b1;
      step();
   endtask

   task automatic test_ram();
      logic [7:0] exp [16];
      int k;
      drive(32'h0000_0010, 1'b1, 8'hA5);
      drive(32'h0000_0010, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_wr_rd: got %h want a5", mem_din); end
      for (int i = 0; i < 16; i++) begin
         exp[i] = 8'($urandom);
         drive(32'h100 + 32'(i), 1'b1, exp[i]);
      end
      for (int i = 0; i < 16; i++) begin
         k = int'($urandom_range(0, 15));
         drive(32'h100 + 32'(k), 1'b0, 8'h00);
         checks++; if (mem_din !== exp[k]) begin errors++; $display("FAIL ram_rand_rd[%0d]: got %h want %h", k, mem_din, exp[k]); end
      end
      drive(32'h0000_0105, 1'b0, 8'h00);
      step(); step();
      checks++; if (mem_din !== exp[5]) begin errors++; $display("FAIL ram_din_hold: got %h want %h", mem_din, exp[5]); end
   endtask

   task automatic test_unmapped();
      drive(32'h0002_0010, 1'b1, 8'h5A);
      drive(32'h0000_0010, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL unmapped_wr_alias: got %h want a5", mem_din); end
      drive(32'h0002_FFFF, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL unmapped_rd: got %h want 00", mem_din); end
      drive(32'h0000_0010, 1'b0, 8'h00);
      drive(32'h0003_0001, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL io_other_rd: got %h want 00", mem_din); end
      drive(32'h0003_0002, 1'b1, 8'h55);
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL io_other_wr: tx_valid got %b want 0", tx_valid); end
   endtask

   task automatic test_tx();
      logic [7:0] seq [2];
      logic [7:0] vals [9];
      seq = '{8'h48, 8'h69};
      tx_ready = 1'b0;
      drive(32'h0003_0000, 1'b1, 8'h48);
      drive(32'h0003_0000, 1'b1, 8'h00);
      drive(32'h0003_0000, 1'b1, 8'h69);
      tx_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== seq[i]) begin
            errors++; $display("FAIL tx_seq[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, seq[i]);
         end
         step();
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got %b want 0", tx_valid); end
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         vals[i] = 8'($urandom_range(1, 255));
         drive(32'h0003_0000, 1'b1, vals[i]);
         if (i == 7) begin
            checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL tx_ovf_early: got %b want 0", tx_overflow); end
         end
      end
      checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL tx_ovf: got %b want 1", tx_overflow); end
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== vals[i]) begin
            errors++; $display("FAIL tx_full_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, vals[i]);
         end
         step();
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_ninth_dropped: got %b want 0", tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_rdy_hold();
      logic [7:0] r [3];
      logic [31:0] exp, got;
      for (int i = 0; i < 3; i++) r[i] = 8'($urandom);
      rx_valid = 1'b1;
      rx_data = r[0]; step();
      rx_data = r[1]; step();
      rx_valid = 1'b0;
      drive(32'h0000_0010, 1'b0, 8'h00);
      rdy_in = 1'b0;
      rx_valid = 1'b1; rx_data = r[2];
      drive(32'h0000_0010, 1'b1, 8'h77);
      rx_valid = 1'b0;
      drive(32'h0003_0000, 1'b0, 8'h00);
      drive(32'h0003_0004, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL rdy_low_din: got %h want a5", mem_din); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rdy_low_rx_ready: got %b want 1", rx_ready); end
      rdy_in = 1'b1;
      exp = m_cnt;
      drive(32'h0003_0004, 1'b0, 8'h00); got[7:0] = mem_din;
      drive(32'h0003_0005, 1'b0, 8'h00); got[15:8] = mem_din;
      drive(32'h0003_0006, 1'b0, 8'h00); got[23:16] = mem_din;
      drive(32'h0003_0007, 1'b0, 8'h00); got[31:24] = mem_din;
      checks++; if (got !== exp) begin errors++; $display("FAIL rdy_low_counter: got %h want %h", got, exp); end
      drive(32'h0000_0010, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL rdy_low_ram: got %h want a5", mem_din); end
      for (int i = 0; i < 3; i++) begin
         drive(32'h0003_0000, 1'b0, 8'h00);
         checks++; if (mem_din !== r[i]) begin errors++; $display("FAIL rdy_low_rx[%0d]: got %h want %h", i, mem_din, r[i]); end
      end
      drive(32'h0003_0000, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_empty_rd: got %h want 00", mem_din); end
   endtask

   task automatic test_rx_full();
      logic [7:0] v [5];
      rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         v[i] = 8'($urandom);
         rx_data = v[i];
         step();
         if (i == 2) begin
            checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_3: got %b want 1", rx_ready); end
         end
         if (i == 3) begin
            checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_full: got %b want 0", rx_ready); end
         end
      end
      rx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(32'h0003_0000, 1'b0, 8'h00);
         checks++; if (mem_din !== v[i]) begin errors++; $display("FAIL rx_full_rd[%0d]: got %h want %h", i, mem_din, v[i]); end
      end
      drive(32'h0003_0000, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_fifth_dropped: got %h want 00", mem_din); end
   endtask

   task automatic test_counter();
      logic [31:0] got;
      rst_in = 1'b0; step(); rst_in = 1'b1;
      repeat (300) step();
      drive(32'h0003_0004, 1'b0, 8'h00); got[7:0] = mem_din;
      drive(32'h0003_0005, 1'b0, 8'h00); got[15:8] = mem_din;
      drive(32'h0003_0006, 1'b0, 8'h00); got[23:16] = mem_din;
      drive(32'h0003_0007, 1'b0, 8'h00); got[31:24] = mem_din;
      checks++; if (got !== 32'd300) begin errors++; $display("FAIL counter_300: got %0d want 300", got); end
      repeat (260) step();
      drive(32'h0003_0005, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'h01) begin errors++; $display("FAIL snap_no_resnap: got %h want 01", mem_din); end
      drive(32'h0003_0000, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_empty_after_rst: got %h want 00", mem_din); end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic        w;
      logic [7:0]  d;
      int          op;
      for (int i = 0; i < 400; i++) begin
         op = int'($urandom_range(0, 9));
         w = 1'b0; d = 8'($urandom);
         case (op)
            0, 1: begin a = 32'h100 + $urandom_range(0, 15); w = 1'b1; end
            2, 3: a = 32'h100 + $urandom_range(0, 15);
            4: a = 32'h0003_0000;
            5: begin a = 32'h0003_0000; w = 1'b1; if ($urandom_range(0, 3) == 0) d = 8'h00; end
            6: a = 32'h0003_0004 + $urandom_range(0, 3);
            7: begin a = 32'h0003_0000 | $urandom_range(1, 3); w = 1'($urandom); end
            8: begin a = 32'h0002_0000 | $urandom_range(0, 32'hFFFF); w = 1'($urandom); end
            default: begin a = 32'h0003_0004; w = ($urandom_range(0, 3) == 0); end
         endcase
         a[31:18] = 14'($urandom);
         mem_a = a; mem_wr = w; mem_dout = d;
         rdy_in = ($urandom_range(0, 3) != 0);
         rx_valid = 1'($urandom); rx_data = 8'($urandom);
         tx_ready = ($urandom_range(0, 2) != 0);
         step();
         checks++; if (mem_din !== m_din) begin errors++; $display("FAIL rand_din[%0d]: got %h want %h", i, mem_din, m_din); end
         checks++; if (tx_valid !== (m_tx.size() != 0)) begin errors++; $display("FAIL rand_tx_valid[%0d]: got %b want %b", i, tx_valid, m_tx.size() != 0); end
         if (m_tx.size() != 0) begin
            checks++; if (tx_data !== m_tx[0]) begin errors++; $display("FAIL rand_tx_data[%0d]: got %h want %h", i, tx_data, m_tx[0]); end
         end
         checks++; if (rx_ready !== (m_rx.size() < RxDepth)) begin errors++; $display("FAIL rand_rx_ready[%0d]: got %b want %b", i, rx_ready, m_rx.size() < RxDepth); end
         checks++; if (halt !== m_halt) begin errors++; $display("FAIL rand_halt[%0d]: got %b want %b", i, halt, m_halt); end
         checks++; if (tx_overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, tx_overflow, m_ovf); end
      end
      mem_a = 32'h0002_0000; mem_wr = 1'b1; mem_dout = 8'h00;
      rdy_in = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0;
      step();
   endtask

   task automatic test_halt_reset();
      rst_in = 1'b0; step(); rst_in = 1'b1; step();
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_cleared: got %b want 0", halt); end
      drive(32'h0003_0000, 1'b1, 8'h41);
      drive(32'h0003_0004, 1'b1, 8'h5A);
      checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halt); end
      checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL halt_tx_head: got %h want 41", tx_data); end
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL halt_tx_zero: got v=%b d=%h want v=1 d=00", tx_valid, tx_data); end
      rx_valid = 1'b1; rx_data = 8'h3C;
      drive(32'h0000_0010, 1'b0, 8'h00);
      rx_valid = 1'b0;
      checks++; if (mem_din !== 8'hA5 || halt !== 1'b1) begin errors++; $display("FAIL halt_serviced: got din=%h halt=%b want din=a5 halt=1", mem_din, halt); end
      tx_ready = 1'b1;
      #2 rst_in = 1'b0;
      #1;
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL midrst_din: got %h want 00", mem_din); end
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL midrst_halt: got %b want 0", halt); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); end
      checks++; if (rx_ready !== 1'b1 || tx_overflow !== 1'b0) begin errors++; $display("FAIL midrst_rx_ovf: got rdy=%b ovf=%b want rdy=1 ovf=0", rx_ready, tx_overflow); end
      tx_ready = 1'b0;
      step(); rst_in = 1'b1;
      drive(32'h0003_0000, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL midrst_rx_flushed: got %h want 00", mem_din); end
      drive(32'h0000_0010, 1'b0, 8'h00);
      checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_survives_rst: got %h want a5", mem_din); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_unmapped();
      test_tx();
      test_rdy_hold();
      test_rx_full();
      test_counter();
      test_random();
      test_halt_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 17, RAM byte-address width (128 KB).
REQ-002 SHALL have parameter TX_DEPTH, default 8, TX FIFO entries (power of 2).
REQ-003 SHALL have parameter RX_DEPTH, default 4, RX FIFO entries (power of 2).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, ports in order:
  clk_in  input  1  system clock, rising edge
  rst_in  input  1  asynchronous reset, active-low
  rdy_in  input  1  CPU-side enable; low freezes the CPU-facing state
  mem_a  input  32  byte address from CPU; only bits 17:0 decoded
  mem_dout  input  8  write data from CPU
  mem_wr  input  1  1 = write, 0 = read
  mem_din  output  8  read data to CPU, registered
  rx_valid  input  1  input byte available
  rx_data  input  8  input byte
  rx_ready  output  1  RX FIFO not full
  tx_valid  output  1  TX FIFO not empty
  tx_data  output  8  TX FIFO head byte
  tx_ready  input  1  sink accepts tx_data
  halt  output  1  sticky program-stop flag
  tx_overflow  output  1  sticky, a TX byte was dropped

Function
REQ-010 SHALL decode regions: mem_a[17]=0 -> RAM at mem_a[16:0]; mem_a[17:16]=2'b10 -> unmapped; mem_a[17:16]=2'b11 -> I/O, offset mem_a[2:0].
REQ-011 SHALL act on the request presented at cycle N only when rdy_in=1 at edge N; with rdy_in=0, RAM, counter, mem_din, halt and FIFO pop/push from the CPU side hold.
REQ-012 SHALL return read data on mem_din after the edge of cycle N, valid for all of cycle N+1 (1-cycle latency); mem_din holds until the next accepted read.
REQ-013 SHALL write RAM at edge N on accepted write; a read of the same address at N+1 returns the new byte.
REQ-014 Unmapped region: reads return 0x00; writes are ignored.
REQ-015 I/O 0x30000 read: pops the RX FIFO head into mem_din; if empty, returns 0x00 with no pop.
REQ-016 I/O 0x30000 write: nonzero byte pushed to TX FIFO; 0x00 ignored; if full, byte dropped and tx_overflow set.
REQ-017 I/O 0x30004 write: sets halt and pushes 0x00 to TX FIFO (overflow rule of REQ-016 applies); data value is ignored.
REQ-018 32-bit cycle counter: +1 every edge with rdy_in=1; wraps 0xFFFFFFFF -> 0.
REQ-019 I/O 0x30004 read: snapshots the counter into a 32-bit latch and returns snapshot[7:0]; reads of 0x30005/6/7 return latch bytes 1/2/3 without re-snapshot.
REQ-020 Other I/O offsets: reads return 0x00; writes are ignored.
REQ-021 TX FIFO: pop on tx_valid&tx_ready at the edge, independent of rdy_in; push and pop in the same cycle leave count unchanged; pop while full frees the slot so a same-cycle push succeeds.
REQ-022 RX FIFO: push on rx_valid&rx_ready, independent of rdy_in; rx_ready=0 when full; push and pop in the same cycle are both honoured.
REQ-023 FIFO pointers SHALL wrap modulo depth; full/empty SHALL be derived from an extra pointer bit or a count.
REQ-024 halt SHALL be sticky until reset; after halt, CPU requests continue to be serviced.

Reset
REQ-030 While rst_in=0: mem_din=0x00, halt=0, tx_overflow=0, tx_valid=0, rx_ready=1, counter=0, snapshot=0, both FIFOs empty.
REQ-031 RAM contents SHALL NOT be cleared by reset.
REQ-032 Reset asserted mid-operation SHALL discard in-flight reads and FIFO contents immediately, without waiting for a clock edge.

Verification
REQ-040 Write 0xA5 to 0x00010, then read 0x00010 on the next cycle -> mem_din=0xA5 in the following cycle.
REQ-041 Write 'H', 0x00, 'i' to 0x30000 with tx_ready=0, then raise tx_ready -> tx_data sequence 0x48, 0x69; tx_valid then drops.
REQ-042 Write 9 nonzero bytes to 0x30000 with tx_ready=0 (TX_DEPTH=8) -> first 8 are kept and tx_overflow=1.
REQ-043 Run 300 cycles with rdy_in=1, then read 0x30004..0x30007 -> bytes form a value equal to the cycle of the 0x30004 read; read 0x30000 with RX FIFO empty -> 0x00.
REQ-044 Hold rdy_in=0 during a RAM write and a 0x30000 read -> RAM, counter and RX FIFO are unchanged, while RX FIFO continues accepting rx_valid pushes.
REQ-045 Write to 0x30004, then pulse rst_in low mid-drain -> halt=1 and tx_data=0x00 before reset; all outputs at REQ-030 values immediately on assertion.
